sbus_read_initiator: RTL

- Synthesizable MBOX-side initiator for the SBUS read protocol; the counterpart of the MF20 memory responder.
- Accepts a quadword read request from the cache/MBOX (address, 4-bit RQ mask, port A or B) and pulses START_A or START_B.
- Samples ACKN and DATA_VALID, then returns each requested word tagged with its word offset.
- Optionally detects non-existent memory (NXM) by timeout.

---
 rtl/sbus_pkg.sv | 20 ++
 rtl/iSBUS.sv | 25 ++
 rtl/sbus_edge_sync.sv | 28 ++
 rtl/sbus_read_initiator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sbus_pkg.sv
// Shared types for the SBUS read initiator: word, physical address and
// request-mask types, the initiator state enum, and the offset helper.
package sbus_pkg;

    typedef logic [0:35]  tW;
    typedef logic [12:35] tPA;
    typedef logic [0:3]   tRQ;

    typedef enum logic [1:0] {IDLE, START, WAIT} tState;

    // Offset of the lowest-numbered requested word still outstanding;
    // rq[0] is word offset 0, so words are returned in ascending order.
    function automatic logic [1:0] lowest_ofs(input tRQ rq);
        if (rq[0])      return 2'd0;
        else if (rq[1]) return 2'd1;
        else if (rq[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

// File: rtl/iSBUS.sv
// SBUS signal bundle between the MBOX-side initiator and a memory responder.
interface iSBUS;
    import sbus_pkg::*;

    logic START_A;
    logic START_B;
    tPA   ADR;
    tRQ   RQ;
    logic ACKN_A;
    logic ACKN_B;
    logic DATA_VALID_A;
    logic DATA_VALID_B;
    tW    D;

    modport mbox (
        output START_A, START_B, ADR, RQ,
        input  ACKN_A, ACKN_B, DATA_VALID_A, DATA_VALID_B, D
    );

    modport mem (
        input  START_A, START_B, ADR, RQ,
        output ACKN_A, ACKN_B, DATA_VALID_A, DATA_VALID_B, D
    );

endinterface

// File: rtl/sbus_edge_sync.sv
// Multi-stage synchronizer for an asynchronous SBUS strobe followed by a
// rising-edge detector on the synchronized level.
module sbus_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              prev;

    // Shift the strobe through the synchronizer and remember the last level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/sbus_read_initiator.sv
// MBOX-side SBUS quadword read initiator. Accepts a masked read request,
// pulses START_A/B, then returns each requested word on a DATA_VALID edge,
// tagged with its word offset.
// Optional NXM timeout detection is enabled by defining SBUS_NXM_TIMEOUT_EN.
module sbus_read_initiator
    import sbus_pkg::*;
#(
    parameter int START_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int NXM_CYC     = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  tPA          req_adr,
    input  tRQ          req_rq,
    input  logic        req_port,
    output logic        rsp_valid,
    output tW           rsp_data,
    output logic [0:1]  rsp_wofs,
    output logic        rsp_last,
    output logic        nxm_err,
    output logic        busy,
    iSBUS.mbox          SBUS
);

    localparam int SCW = $clog2(START_CYC + 1);
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYC - 1);

    tState          state, state_nx;
    logic [12:33]   adr_q, adr_nx;
    tRQ             rq_q, rq_nx;
    logic           port_q, port_nx;
    tRQ             pend, pend_nx;
    logic [SCW-1:0] start_cnt, start_cnt_nx;
    logic           rsp_valid_nx, rsp_last_nx, nxm_nx;
    tW              rsp_data_nx;
    logic [0:1]     rsp_wofs_nx;
    logic [1:0]     cur_ofs;
    logic           dva_rise, dvb_rise, dv_rise;
    logic           timeout;
    logic           unused_adr;

    assign unused_adr = &{1'b0, req_adr[34:35]};

    sbus_edge_sync #(.STAGES(SYNC_STAGES)) u_dva (
        .clk(clk), .reset_n(reset_n), .din(SBUS.DATA_VALID_A), .rise(dva_rise)
    );
    sbus_edge_sync #(.STAGES(SYNC_STAGES)) u_dvb (
        .clk(clk), .reset_n(reset_n), .din(SBUS.DATA_VALID_B), .rise(dvb_rise)
    );

    assign dv_rise   = port_q ? dvb_rise : dva_rise;
    assign cur_ofs   = lowest_ofs(pend);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign SBUS.START_A = (state == START) && !port_q;
    assign SBUS.START_B = (state == START) &&  port_q;
    assign SBUS.ADR     = {adr_q, 2'b00};
    assign SBUS.RQ      = rq_q;

`ifdef SBUS_NXM_TIMEOUT_EN
    localparam int NW = $clog2(NXM_CYC + 1);
    localparam logic [NW-1:0] NXM_LAST = NW'(NXM_CYC - 1);

    logic          acka_rise, ackb_rise, ack_rise, ack_seen;
    logic [NW-1:0] word_cnt, ack_cnt;

    sbus_edge_sync #(.STAGES(SYNC_STAGES)) u_acka (
        .clk(clk), .reset_n(reset_n), .din(SBUS.ACKN_A), .rise(acka_rise)
    );
    sbus_edge_sync #(.STAGES(SYNC_STAGES)) u_ackb (
        .clk(clk), .reset_n(reset_n), .din(SBUS.ACKN_B), .rise(ackb_rise)
    );

    assign ack_rise = port_q ? ackb_rise : acka_rise;
    assign timeout  = (state == WAIT) &&
                      (((pend != '0) && (word_cnt == NXM_LAST)) ||
                       (!ack_seen && (ack_cnt == NXM_LAST)));

    // Per-word and since-START watchdogs; both restart when a new START begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            ack_cnt  <= '0;
            ack_seen <= 1'b0;
        end else if (state == IDLE) begin
            word_cnt <= '0;
            ack_cnt  <= '0;
            ack_seen <= 1'b0;
        end else begin
            if ((state == WAIT) && dv_rise)
                word_cnt <= '0;
            else if (word_cnt != NXM_LAST)
                word_cnt <= word_cnt + 1'b1;
            if (ack_rise)
                ack_seen <= 1'b1;
            if (!ack_seen && (ack_cnt != NXM_LAST))
                ack_cnt <= ack_cnt + 1'b1;
        end
    end
`else
    logic unused_nxm;
    assign unused_nxm = &{1'b0, SBUS.ACKN_A, SBUS.ACKN_B, NXM_CYC[0]};
    assign timeout    = 1'b0;
`endif

    // State and datapath registers; everything returns to idle values on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            adr_q     <= '0;
            rq_q      <= '0;
            port_q    <= 1'b0;
            pend      <= '0;
            start_cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_wofs  <= '0;
            rsp_last  <= 1'b0;
            nxm_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            adr_q     <= adr_nx;
            rq_q      <= rq_nx;
            port_q    <= port_nx;
            pend      <= pend_nx;
            start_cnt <= start_cnt_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
            rsp_wofs  <= rsp_wofs_nx;
            rsp_last  <= rsp_last_nx;
            nxm_err   <= nxm_nx;
        end
    end

    // Next-state logic: accept, hold START, then retire one word per DATA_VALID edge.
    always_comb begin
        state_nx     = state;
        adr_nx       = adr_q;
        rq_nx        = rq_q;
        port_nx      = port_q;
        pend_nx      = pend;
        start_cnt_nx = start_cnt;
        rsp_valid_nx = 1'b0;
        rsp_data_nx  = rsp_data;
        rsp_wofs_nx  = rsp_wofs;
        rsp_last_nx  = 1'b0;
        nxm_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    adr_nx       = req_adr[12:33];
                    rq_nx        = req_rq;
                    port_nx      = req_port;
                    pend_nx      = req_rq;
                    start_cnt_nx = '0;
                    if (req_rq != '0)
                        state_nx = START;
                end
            end
            START: begin
                start_cnt_nx = start_cnt + 1'b1;
                if (start_cnt == START_LAST)
                    state_nx = WAIT;
            end
            WAIT: begin
                if (pend == '0) begin
                    state_nx = IDLE;
                    adr_nx   = '0;
                    rq_nx    = '0;
                end else if (dv_rise) begin
                    rsp_valid_nx     = 1'b1;
                    rsp_data_nx      = SBUS.D;
                    rsp_wofs_nx      = cur_ofs;
                    pend_nx[cur_ofs] = 1'b0;
                    rsp_last_nx      = (pend_nx == '0);
                end else if (timeout) begin
                    nxm_nx   = 1'b1;
                    state_nx = IDLE;
                    adr_nx   = '0;
                    rq_nx    = '0;
                    pend_nx  = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
